// File: rtl/alarm_controller_if.sv
// Signal bundle between the alarm top level and alarm_controller.
// Optional member trig_door exists only when ALARM_TRIG_LOG_EN is defined.
//
// Handshake: there is no valid/ready pair on this bundle. ignition, doors,
// time_select and time_value are level signals sampled on every rising clock
// edge. reprogram is a one-cycle write strobe with no ready: a write that
// qualifies (ignition=1) always lands on the edge it is sampled. All outputs
// are registered and change only on the rising edge.
interface alarm_controller_if #(
    parameter int N_DOORS = 2,
    parameter int VAL_W   = 4
);
    logic               ignition;
    logic [N_DOORS-1:0] doors;
    logic               reprogram;
    logic [1:0]         time_select;
    logic [VAL_W-1:0]   time_value;
    logic [2:0]         state;
    logic [VAL_W-1:0]   countdown;
    logic               status;
    logic [2:0]         siren;
`ifdef ALARM_TRIG_LOG_EN
    logic [N_DOORS-1:0] trig_door;
`endif

    // Sensor/control side: drives inputs, observes the controller.
    modport master (
        output ignition, doors, reprogram, time_select, time_value,
`ifdef ALARM_TRIG_LOG_EN
        input  trig_door,
`endif
        input  state, countdown, status, siren
    );

    // Controller side.
    modport slave (
        input  ignition, doors, reprogram, time_select, time_value,
`ifdef ALARM_TRIG_LOG_EN
        output trig_door,
`endif
        output state, countdown, status, siren
    );
endinterface

// File: rtl/alarm_controller.sv
// Door-count-generic anti-theft controller: DISARMED -> ARMING -> ARMED ->
// TRIGGERED -> SOUNDING, with its own second-tick prescaler, a countdown for
// the timed states and four run-time programmable delays.
// Optional macro ALARM_TRIG_LOG_EN adds trig_door, a record of which doors
// tripped the alarm.
module alarm_controller #(
    parameter int N_DOORS  = 2,
    parameter int VAL_W    = 4,
    parameter int TICK_DIV = 50000000,
    parameter int DEF_ARM  = 6,
    parameter int DEF_DRV  = 8,
    parameter int DEF_PASS = 15,
    parameter int DEF_ON   = 10
) (
    input  logic              clock,
    input  logic              reset,
    alarm_controller_if.slave bus
);

    typedef enum logic [2:0] {
        S_DISARMED  = 3'd0,
        S_ARMING    = 3'd1,
        S_ARMED     = 3'd2,
        S_TRIGGERED = 3'd3,
        S_SOUNDING  = 3'd4
    } state_t;

    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_t           st;
    logic [VAL_W-1:0] cnt;
    logic [PW-1:0]    presc;
    logic             blink;
    logic             drv_seen;
    logic             status_q;
    logic [2:0]       siren_q;
    logic [VAL_W-1:0] t_arm;
    logic [VAL_W-1:0] t_drv;
    logic [VAL_W-1:0] t_pass;
    logic [VAL_W-1:0] t_on;

    logic tick;
    logic any_door;
    logic last_tick;

    assign tick      = (presc == PRESC_LAST);
    assign any_door  = |bus.doors;
    // The tick that takes the counter from 1 to 0 ends the timed state.
    assign last_tick = tick && (cnt == VAL_W'(1));

    // A programmed delay of zero still lasts one full tick.
    function automatic logic [VAL_W-1:0] eff(input logic [VAL_W-1:0] v);
        return (v == '0) ? VAL_W'(1) : v;
    endfunction

    // Delay parameters: writable only while the ignition is on.
    always_ff @(posedge clock) begin
        if (!reset) begin
            t_arm  <= VAL_W'(DEF_ARM);
            t_drv  <= VAL_W'(DEF_DRV);
            t_pass <= VAL_W'(DEF_PASS);
            t_on   <= VAL_W'(DEF_ON);
        end else if (bus.reprogram && bus.ignition) begin
            case (bus.time_select)
                2'd0: t_arm  <= bus.time_value;
                2'd1: t_drv  <= bus.time_value;
                2'd2: t_pass <= bus.time_value;
                2'd3: t_on   <= bus.time_value;
            endcase
        end
    end

    // Main FSM with prescaler, blink, countdown and registered LED/siren.
    always_ff @(posedge clock) begin
        if (!reset) begin
            st       <= S_DISARMED;
            cnt      <= '0;
            presc    <= '0;
            blink    <= 1'b0;
            drv_seen <= 1'b0;
            status_q <= 1'b0;
            siren_q  <= 3'b000;
        end else begin
            // Free-running tick; countdown loads below override the clear.
            presc <= tick ? '0 : presc + 1'b1;
            blink <= blink ^ tick;

            // Outputs follow the state held before this edge.
            case (st)
                S_ARMED:                          status_q <= blink;
                S_ARMING, S_TRIGGERED, S_SOUNDING: status_q <= 1'b1;
                default:                          status_q <= 1'b0;
            endcase
            siren_q <= (st == S_SOUNDING) ? (blink ? 3'b100 : 3'b001) : 3'b000;

            if (bus.ignition) begin
                st  <= S_DISARMED;
                cnt <= '0;
            end else begin
                case (st)
                    S_DISARMED: begin
                        if (drv_seen && !any_door) begin
                            st       <= S_ARMING;
                            cnt      <= eff(t_arm);
                            presc    <= '0;
                            drv_seen <= 1'b0;
                        end else if (bus.doors[0]) begin
                            drv_seen <= 1'b1;
                        end
                    end
                    S_ARMING: begin
                        if (any_door) begin
                            st       <= S_DISARMED;
                            cnt      <= '0;
                            drv_seen <= bus.doors[0];
                        end else if (last_tick) begin
                            st  <= S_ARMED;
                            cnt <= '0;
                        end else if (tick) begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    S_ARMED: begin
                        if (any_door) begin
                            st    <= S_TRIGGERED;
                            cnt   <= eff(bus.doors[0] ? t_drv : t_pass);
                            presc <= '0;
                        end
                    end
                    S_TRIGGERED: begin
                        if (last_tick) begin
                            st    <= S_SOUNDING;
                            cnt   <= eff(t_on);
                            presc <= '0;
                        end else if (tick) begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    S_SOUNDING: begin
                        if (any_door) begin
                            cnt   <= eff(t_on);
                            presc <= '0;
                        end else if (last_tick) begin
                            st  <= S_ARMED;
                            cnt <= '0;
                        end else if (tick) begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: begin
                        st       <= S_DISARMED;
                        cnt      <= '0;
                        drv_seen <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef ALARM_TRIG_LOG_EN
    logic [N_DOORS-1:0] trig_q;

    // Remember the doors that tripped the alarm until the car is disarmed.
    always_ff @(posedge clock) begin
        if (!reset) begin
            trig_q <= '0;
        end else if (bus.ignition) begin
            trig_q <= '0;
        end else if (st == S_ARMED && any_door) begin
            trig_q <= bus.doors;
        end else if (st == S_ARMING && any_door) begin
            trig_q <= '0;
        end else if (st != S_ARMING && st != S_ARMED &&
                     st != S_TRIGGERED && st != S_SOUNDING) begin
            trig_q <= '0;
        end
    end

    assign bus.trig_door = trig_q;
`endif

    assign bus.state     = st;
    assign bus.countdown = cnt;
    assign bus.status    = status_q;
    assign bus.siren     = siren_q;

endmodule
